// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed scan controller for a 4-digit
// common-anode seven-segment display. Each digit slot starts dark for BLANK
// cycles to hide ghosting, and the displayed ALU result/opcode are only
// committed at the start of a frame so a digit never shows a torn value.
module seven_seg_scanner #(
  parameter int DIV   = 100000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] y_in,
  input  logic [3:0]  op_in,
  output logic [3:0]  anode,
  output logic [3:0]  an_n,
  output logic [15:0] y_hold,
  output logic [3:0]  op_hold,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;
  localparam bit NO_BLANK = (BLANK == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;
  logic [1:0]       next_digit;
  logic [15:0]      pend_y;
  logic [3:0]       pend_op;
  logic             pend_valid;
  logic             slot_end;
  logic             frame_start;

  function automatic logic [3:0] onehot(input logic [1:0] d);
    onehot = 4'b0001 << d;
  endfunction

  // Slot-end and frame-start detection; a frame starts on leaving IDLE or on the 3->0 wrap.
  always_comb begin
    next_digit  = digit + 2'd1;
    slot_end    = (state != S_IDLE) && en && (cnt == SLOT_LAST);
    frame_start = ((state == S_IDLE) && en) || (slot_end && (digit == 2'd3));
  end

  // Scan state machine, snapshot registers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      digit      <= 2'd0;
      anode      <= 4'b0001;
      an_n       <= 4'b1111;
      y_hold     <= 16'h0000;
      op_hold    <= 4'h0;
      pend_y     <= 16'h0000;
      pend_op    <= 4'h0;
      pend_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (frame_start && pend_valid) begin
        y_hold     <= pend_y;
        op_hold    <= pend_op;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_y     <= y_in;
        pend_op    <= op_in;
        pend_valid <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          cnt   <= '0;
          digit <= 2'd0;
          anode <= 4'b0001;
          an_n  <= 4'b1111;
          if (en) begin
            if (NO_BLANK) begin
              state <= S_SHOW;
              an_n  <= 4'b1110;
            end else begin
              state <= S_BLANK;
            end
          end
        end
        default: begin
          if (!en) begin
            state <= S_IDLE;
            cnt   <= '0;
            digit <= 2'd0;
            anode <= 4'b0001;
            an_n  <= 4'b1111;
          end else if (slot_end) begin
            cnt        <= '0;
            digit      <= next_digit;
            anode      <= onehot(next_digit);
            frame_done <= (digit == 2'd3);
            if (NO_BLANK) begin
              state <= S_SHOW;
              an_n  <= ~onehot(next_digit);
            end else begin
              state <= S_BLANK;
              an_n  <= 4'b1111;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if ((state == S_BLANK) && (cnt == BLANK_LAST)) begin
              state <= S_SHOW;
              an_n  <= ~anode;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: drives two scanner instances (DIV=8/BLANK=2 and
// DIV=4/BLANK=0) with shared inputs and compares them every cycle against a
// timeline model: time since activation determines digit and dark/show phase.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] y_in = 16'h0000;
  logic [3:0]  op_in = 4'h0;

  logic [3:0]  anode_w [2];
  logic [3:0]  an_n_w [2];
  logic [15:0] y_hold_w [2];
  logic [3:0]  op_hold_w [2];
  logic        frame_done_w [2];

  int dv [2] = '{8, 4};
  int bl [2] = '{2, 0};

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  int          m_t [2];
  bit          m_act [2];
  bit          m_fd [2];
  bit          m_pv [2];
  logic [15:0] m_y [2];
  logic [15:0] m_py [2];
  logic [3:0]  m_op [2];
  logic [3:0]  m_pop [2];

  // Free-running clock.
  always #5 clk = ~clk;

  seven_seg_scanner #(.DIV(8), .BLANK(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .y_in(y_in), .op_in(op_in),
    .anode(anode_w[0]), .an_n(an_n_w[0]), .y_hold(y_hold_w[0]),
    .op_hold(op_hold_w[0]), .frame_done(frame_done_w[0])
  );

  seven_seg_scanner #(.DIV(4), .BLANK(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .y_in(y_in), .op_in(op_in),
    .anode(anode_w[1]), .an_n(an_n_w[1]), .y_hold(y_hold_w[1]),
    .op_hold(op_hold_w[1]), .frame_done(frame_done_w[1])
  );

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int curDigit(input int i);
    return (m_t[i] / dv[i]) % 4;
  endfunction

  function automatic bit isShowing(input int i);
    return m_act[i] && ((m_t[i] % dv[i]) >= bl[i]);
  endfunction

  function automatic logic [3:0] expAnN(input int i);
    logic [3:0] oh;
    oh = 4'b0001 << curDigit(i);
    return isShowing(i) ? ~oh : 4'b1111;
  endfunction

  // Reference model: activation time, frame boundaries and snapshot pipeline.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_t[i] <= 0; m_act[i] <= 1'b0; m_fd[i] <= 1'b0; m_pv[i] <= 1'b0;
        m_y[i] <= 16'h0; m_op[i] <= 4'h0; m_py[i] <= 16'h0; m_pop[i] <= 4'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int nt;
        bit na, fd, commit, pv;
        nt = m_t[i]; na = m_act[i]; fd = 1'b0; commit = 1'b0; pv = m_pv[i];
        if (!m_act[i]) begin
          if (en) begin na = 1'b1; nt = 0; commit = 1'b1; end
        end else if (!en) begin
          na = 1'b0; nt = 0;
        end else begin
          nt = m_t[i] + 1;
          if (nt == 4 * dv[i]) begin nt = 0; fd = 1'b1; commit = 1'b1; end
        end
        if (commit && m_pv[i]) begin
          m_y[i] <= m_py[i]; m_op[i] <= m_pop[i]; pv = 1'b0;
        end
        if (load) begin
          m_py[i] <= y_in; m_pop[i] <= op_in; pv = 1'b1;
        end
        m_t[i] <= nt; m_act[i] <= na; m_fd[i] <= fd; m_pv[i] <= pv;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("an_n%0d", i), {12'h0, an_n_w[i]}, {12'h0, expAnN(i)});
        if (m_act[i])
          checkOutput($sformatf("anode%0d", i), {12'h0, anode_w[i]}, {12'h0, 4'b0001 << curDigit(i)});
        checkOutput($sformatf("y_hold%0d", i), y_hold_w[i], m_y[i]);
        checkOutput($sformatf("op_hold%0d", i), {12'h0, op_hold_w[i]}, {12'h0, m_op[i]});
        checkOutput($sformatf("frame_done%0d", i), {15'h0, frame_done_w[i]}, {15'h0, m_fd[i]});
      end
    end
  end

  task automatic applyStimulus(input logic e, input logic l, input logic [15:0] y, input logic [3:0] op);
    en = e; load = l; y_in = y; op_in = op;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(en, 1'b0, y_in, op_in);
  endtask

  task automatic waitSlot(input int d, input bit showing);
    bit found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (m_act[0] && curDigit(0) == d && isShowing(0) == showing) found = 1'b1;
      else applyStimulus(en, 1'b0, y_in, op_in);
    end
    if (!found) checkOutput("wait_slot_timeout", 16'h0, 16'h1);
  endtask

  task automatic waitCycle(input int tt);
    bit found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (m_act[0] && m_t[0] == tt) found = 1'b1;
      else applyStimulus(en, 1'b0, y_in, op_in);
    end
    if (!found) checkOutput("wait_cycle_timeout", 16'h0, 16'h1);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst_an_n%0d", i), {12'h0, an_n_w[i]}, 16'h000F);
      checkOutput($sformatf("rst_anode%0d", i), {12'h0, anode_w[i]}, 16'h0001);
      checkOutput($sformatf("rst_y_hold%0d", i), y_hold_w[i], 16'h0000);
      checkOutput($sformatf("rst_frame_done%0d", i), {15'h0, frame_done_w[i]}, 16'h0000);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    idleCycles(3);

    $display("[TB] scan sequence");
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0);
    idleCycles(70);

    $display("[TB] tear-free load");
    waitSlot(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'hA5C3, 4'h4);
    waitSlot(2, 1'b1);
    checkOutput("tear_digit2", y_hold_w[0], 16'h0000);
    waitSlot(3, 1'b1);
    checkOutput("tear_digit3", y_hold_w[0], 16'h0000);
    waitSlot(0, 1'b0);
    checkOutput("tear_commit_y", y_hold_w[0], 16'hA5C3);
    checkOutput("tear_commit_op", {12'h0, op_hold_w[0]}, 16'h0004);

    $display("[TB] overwrite");
    waitSlot(1, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h1111, 4'h1);
    idleCycles(3);
    applyStimulus(1'b1, 1'b1, 16'h2222, 4'h2);
    waitSlot(0, 1'b0);
    checkOutput("overwrite_y", y_hold_w[0], 16'h2222);
    checkOutput("overwrite_op", {12'h0, op_hold_w[0]}, 16'h0002);

    $display("[TB] load on commit edge");
    waitSlot(2, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h3333, 4'h3);
    waitCycle(31);
    applyStimulus(1'b1, 1'b1, 16'h4444, 4'h5);
    checkOutput("coincide_old_y", y_hold_w[0], 16'h3333);
    waitSlot(1, 1'b1);
    waitSlot(0, 1'b0);
    checkOutput("coincide_new_y", y_hold_w[0], 16'h4444);
    checkOutput("coincide_new_op", {12'h0, op_hold_w[0]}, 16'h0005);

    $display("[TB] enable abort");
    waitSlot(2, 1'b1);
    applyStimulus(1'b0, 1'b0, y_in, op_in);
    checkOutput("abort_an_n", {12'h0, an_n_w[0]}, 16'h000F);
    checkOutput("abort_frame_done", {15'h0, frame_done_w[0]}, 16'h0000);
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, y_in, op_in);
    checkOutput("restart_blank1", {12'h0, an_n_w[0]}, 16'h000F);
    checkOutput("restart_anode", {12'h0, anode_w[0]}, 16'h0001);
    checkOutput("restart_show1", {12'h0, an_n_w[1]}, 16'h000E);
    idleCycles(1);
    checkOutput("restart_blank2", {12'h0, an_n_w[0]}, 16'h000F);
    idleCycles(1);
    checkOutput("restart_show", {12'h0, an_n_w[0]}, 16'h000E);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(0, 63) != 0, $urandom_range(0, 7) == 0,
                    16'($urandom), 4'($urandom));
    end

    $display("[TB] async reset during show");
    applyStimulus(1'b1, 1'b0, y_in, op_in);
    waitSlot(3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_an_n0", {12'h0, an_n_w[0]}, 16'h000F);
    checkOutput("areset_an_n1", {12'h0, an_n_w[1]}, 16'h000F);
    checkOutput("areset_y_hold0", y_hold_w[0], 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, y_in, op_in);
    idleCycles(3);
    checkOutput("post_reset_idle", {12'h0, an_n_w[0]}, 16'h000F);
    applyStimulus(1'b1, 1'b0, y_in, op_in);
    idleCycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
